pipe_decode: RTL and testbench
==============================

Name: pipe_decode

Overview:
- Parametrised, pipelined LEGv8 decode stage: IF/ID input handshake, internal 32-entry register file, control decode, sign extension and a registered ID/EX output with valid/ready.
- Adds three things to the single-cycle decode:
  - same-cycle writeback bypass;
  - held-output refresh;
  - configurable load-use stall with bubble insertion.
- Sits between the fetch stage and the execute stage.

Parameters:
WORD, 64, datapath/register width in bits (32 or 64)
INSTR_LEN, 32, instruction width
LOAD_STALL, 1, bubble cycles forced after LDUR before a dependent instruction (0 disables, max 3)

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  fetch offers instruction
in_ready  out  1  instruction accepted when in_valid && in_ready
in_instr  in  INSTR_LEN  instruction
in_pc  in  WORD  instruction address
flush  in  1  synchronous squash of the output register and hazard state
wb_en  in  1  register write enable from writeback
wb_addr  in  5  write register
wb_data  in  WORD  write data
out_valid  out  1  ID/EX register holds a valid instruction
out_ready  in  1  execute consumes when out_valid && out_ready
out_opcode  out  11  instr[31:21]
out_pc  out  WORD  registered PC
out_rd  out  5  instr[4:0]
out_read_data1, out_read_data2  out  WORD  operands
out_sign_ext  out  WORD  extended immediate
out_uncond_branch, out_branch, out_mem_read, out_mem_to_reg, out_mem_write, out_alu_src, out_reg_write, out_illegal  out  1 each  control
out_alu_op  out  2  00 mem, 01 CBZ, 10 R-type

Behaviour:
- Reset (rst_n low, asynchronous):
  - all 32 registers cleared to 0;
  - out_valid=0, all out_* fields 0;
  - hazard state cleared.
- Decode (combinational on in_instr), applied to LDUR 11111000010, STUR 11111000000, CBZ 10110100xxx, B 000101xxxxx, and R-type ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000:
  - reg2loc=1 for STUR/CBZ.
  - Unknown opcode: all controls 0, out_illegal=1, no source registers.
- Sources:
  - rn = instr[9:5] for R-type, LDUR and STUR.
  - reg2 = reg2loc ? instr[4:0] : instr[20:16] for R-type, STUR and CBZ.
  - B has no sources.
- Sign extension:
  - D-type: instr[20:12]
  - CBZ: instr[23:5]
  - B: instr[25:0]
  - Each sign-extended to WORD; R-type gives 0.
- Register file:
  - X31 reads 0; writes to X31 are ignored.
  - Write happens at the clock edge when wb_en=1.
  - Read bypass: if wb_en && wb_addr==src && src!=31, the read returns wb_data in the same cycle.
- Handshake:
  - in_ready = !flush && !hazard && (!out_valid || out_ready).
  - On accept, the output register loads all fields next edge with 1-cycle latency, and out_valid=1.
  - If there is no accept and out_ready=1, out_valid goes to 0.
  - If out_valid && !out_ready, every field holds.
  - Held refresh: while holding, a wb_en write to the held rn/reg2 (≠31) updates the corresponding out_read_data that edge.
- Load-use (LOAD_STALL>0):
  - Loading LDUR with Rt≠31 into the output register sets ld_pending, ld_rd=Rt and cnt=0.
  - Each later edge with no accept and no held output increments cnt; this is a bubble cycle.
  - When cnt reaches LOAD_STALL, ld_pending clears.
  - hazard = ld_pending && new instr sources ld_rd.
  - Accepting a non-dependent instruction clears ld_pending, unless that instruction is itself an LDUR, which re-arms it.
- Flush:
  - Clears out_valid, ld_pending and cnt next edge.
  - The register file and wb_en writes are unaffected.
  - Flush has priority over an accept in the same cycle.
- Simultaneous events:
  - Accept and consume in the same cycle is a back-to-back transfer, with no bubble.
  - Writeback and read of the same register in the same cycle: the new data wins.

Test Plan:
- Write X1=0x5 via wb; offer ADD X2,X1,X1 with out_ready=1 -> next cycle out_valid=1, out_read_data1/2=0x5, out_alu_op=10, out_reg_write=1.
- LDUR X3,[X0,#-8], then ADD X4,X3,X1 with LOAD_STALL=1 -> in_ready=0 for one cycle, one out_valid=0 bubble, then ADD issues; with LOAD_STALL=0 -> no bubble.
- Same cycle: wb_en=1, wb_addr=5, wb_data=0xAB while SUB X6,X5,X5 is decoded -> out_read_data1=out_read_data2=0xAB.
- out_ready=0 holding ORR reading X7; wb writes X7=0x99 -> held out_read_data1 becomes 0x99 and the other fields are unchanged.
- B with imm26=0x3FFFFFF -> out_sign_ext=all ones, out_uncond_branch=1; undefined opcode 0x000 -> out_illegal=1, controls 0.
- Assert rst_n low mid-stall, then flush during an offer -> out_valid=0 and hazard cleared; the next ADD is accepted immediately.

Source files
------------

// File: rtl/pipe_decode.sv
// LEGv8 decode stage: IF/ID handshake, 32-entry register file with writeback bypass,
// control decode, sign extension, and a registered ID/EX output with load-use stall.
module pipe_decode #(
  parameter int WORD       = 64,
  parameter int INSTR_LEN  = 32,
  parameter int LOAD_STALL = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [INSTR_LEN-1:0] in_instr,
  input  logic [WORD-1:0]      in_pc,
  input  logic                 flush,
  input  logic                 wb_en,
  input  logic [4:0]           wb_addr,
  input  logic [WORD-1:0]      wb_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [10:0]          out_opcode,
  output logic [WORD-1:0]      out_pc,
  output logic [4:0]           out_rd,
  output logic [WORD-1:0]      out_read_data1,
  output logic [WORD-1:0]      out_read_data2,
  output logic [WORD-1:0]      out_sign_ext,
  output logic                 out_uncond_branch,
  output logic                 out_branch,
  output logic                 out_mem_read,
  output logic                 out_mem_to_reg,
  output logic                 out_mem_write,
  output logic                 out_alu_src,
  output logic                 out_reg_write,
  output logic                 out_illegal,
  output logic [1:0]           out_alu_op
);

  localparam logic [2:0] STALL_N = 3'(LOAD_STALL);

  logic [WORD-1:0] rf [32];

  logic            d_uncond, d_branch, d_mem_read, d_mem_to_reg, d_mem_write;
  logic            d_alu_src, d_reg_write, d_illegal, reg2loc, use_rn, use_r2;
  logic [1:0]      d_alu_op;
  logic [WORD-1:0] d_imm, rd1, rd2;
  logic [4:0]      rs1, rs2, held_rs1, held_rs2;

  logic            ld_pending;
  logic [4:0]      ld_rd;
  logic [1:0]      cnt;
  logic [2:0]      cnt_nx;
  logic            hazard, accept, hold;

  always_comb begin
    d_uncond     = 1'b0;
    d_branch     = 1'b0;
    d_mem_read   = 1'b0;
    d_mem_to_reg = 1'b0;
    d_mem_write  = 1'b0;
    d_alu_src    = 1'b0;
    d_reg_write  = 1'b0;
    d_illegal    = 1'b0;
    d_alu_op     = 2'b00;
    reg2loc      = 1'b0;
    use_rn       = 1'b0;
    use_r2       = 1'b0;
    d_imm        = '0;
    casez (in_instr[31:21])
      11'b11111000010: begin // LDUR
        d_mem_read = 1'b1; d_mem_to_reg = 1'b1; d_alu_src = 1'b1; d_reg_write = 1'b1;
        use_rn = 1'b1;
        d_imm = {{(WORD-9){in_instr[20]}}, in_instr[20:12]};
      end
      11'b11111000000: begin // STUR
        d_mem_write = 1'b1; d_alu_src = 1'b1; reg2loc = 1'b1;
        use_rn = 1'b1; use_r2 = 1'b1;
        d_imm = {{(WORD-9){in_instr[20]}}, in_instr[20:12]};
      end
      11'b10110100???: begin // CBZ
        d_branch = 1'b1; d_alu_op = 2'b01; reg2loc = 1'b1; use_r2 = 1'b1;
        d_imm = {{(WORD-19){in_instr[23]}}, in_instr[23:5]};
      end
      11'b000101?????: begin // B
        d_uncond = 1'b1;
        d_imm = {{(WORD-26){in_instr[25]}}, in_instr[25:0]};
      end
      11'b10001011000, 11'b11001011000, 11'b10001010000, 11'b10101010000: begin
        d_reg_write = 1'b1; d_alu_op = 2'b10; use_rn = 1'b1; use_r2 = 1'b1;
      end
      default: d_illegal = 1'b1;
    endcase
  end

  // Unused sources read X31, so they return 0 and never match a hazard or refresh.
  assign rs1 = use_rn ? in_instr[9:5] : 5'd31;
  assign rs2 = use_r2 ? (reg2loc ? in_instr[4:0] : in_instr[20:16]) : 5'd31;

  assign rd1 = (rs1 == 5'd31) ? '0 : (wb_en && wb_addr == rs1) ? wb_data : rf[rs1];
  assign rd2 = (rs2 == 5'd31) ? '0 : (wb_en && wb_addr == rs2) ? wb_data : rf[rs2];

  assign hazard   = ld_pending && (rs1 == ld_rd || rs2 == ld_rd);
  assign in_ready = !flush && !hazard && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign hold     = out_valid && !out_ready;
  assign cnt_nx   = {1'b0, cnt} + 3'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else if (wb_en && wb_addr != 5'd31) begin
      rf[wb_addr] <= wb_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid         <= 1'b0;
      out_opcode        <= '0;
      out_pc            <= '0;
      out_rd            <= '0;
      out_read_data1    <= '0;
      out_read_data2    <= '0;
      out_sign_ext      <= '0;
      out_uncond_branch <= 1'b0;
      out_branch        <= 1'b0;
      out_mem_read      <= 1'b0;
      out_mem_to_reg    <= 1'b0;
      out_mem_write     <= 1'b0;
      out_alu_src       <= 1'b0;
      out_reg_write     <= 1'b0;
      out_illegal       <= 1'b0;
      out_alu_op        <= 2'b00;
      held_rs1          <= 5'd31;
      held_rs2          <= 5'd31;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid         <= 1'b1;
      out_opcode        <= in_instr[31:21];
      out_pc            <= in_pc;
      out_rd            <= in_instr[4:0];
      out_read_data1    <= rd1;
      out_read_data2    <= rd2;
      out_sign_ext      <= d_imm;
      out_uncond_branch <= d_uncond;
      out_branch        <= d_branch;
      out_mem_read      <= d_mem_read;
      out_mem_to_reg    <= d_mem_to_reg;
      out_mem_write     <= d_mem_write;
      out_alu_src       <= d_alu_src;
      out_reg_write     <= d_reg_write;
      out_illegal       <= d_illegal;
      out_alu_op        <= d_alu_op;
      held_rs1          <= rs1;
      held_rs2          <= rs2;
    end else if (hold) begin
      // Keep a stalled operand coherent with writebacks landing behind it.
      if (wb_en && wb_addr == held_rs1 && held_rs1 != 5'd31) out_read_data1 <= wb_data;
      if (wb_en && wb_addr == held_rs2 && held_rs2 != 5'd31) out_read_data2 <= wb_data;
    end else begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ld_pending <= 1'b0;
      ld_rd      <= '0;
      cnt        <= '0;
    end else if (flush) begin
      ld_pending <= 1'b0;
      cnt        <= '0;
    end else if (accept) begin
      if (STALL_N != 3'd0 && d_mem_read && in_instr[4:0] != 5'd31) begin
        ld_pending <= 1'b1;
        ld_rd      <= in_instr[4:0];
        cnt        <= '0;
      end else begin
        ld_pending <= 1'b0;
      end
    end else if (ld_pending && !hold) begin
      cnt <= cnt_nx[1:0];
      if (cnt_nx >= STALL_N) ld_pending <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pipe_decode.sv
// Directed bench for pipe_decode: driver pushes hand-computed ID/EX records into a
// queue, a monitor pops and compares on every out_valid && out_ready transfer.
module tb_pipe_decode;

  localparam int W = 282;

  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;

  // ctrl order: uncond, branch, mem_read, mem_to_reg, mem_write, alu_src, reg_write, illegal
  localparam logic [7:0] C_R    = 8'b00000010;
  localparam logic [7:0] C_LDUR = 8'b00110110;
  localparam logic [7:0] C_STUR = 8'b00001100;
  localparam logic [7:0] C_CBZ  = 8'b01000000;
  localparam logic [7:0] C_B    = 8'b10000000;
  localparam logic [7:0] C_ILL  = 8'b00000001;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0, in_ready;
  logic [31:0] in_instr = '0;
  logic [63:0] in_pc = '0;
  logic        flush = 1'b0, wb_en = 1'b0;
  logic [4:0]  wb_addr = '0;
  logic [63:0] wb_data = '0;
  logic        out_valid, out_ready = 1'b1;
  logic [10:0] out_opcode;
  logic [63:0] out_pc, out_read_data1, out_read_data2, out_sign_ext;
  logic [4:0]  out_rd;
  logic        out_uncond_branch, out_branch, out_mem_read, out_mem_to_reg;
  logic        out_mem_write, out_alu_src, out_reg_write, out_illegal;
  logic [1:0]  out_alu_op;

  logic        ns_in_valid = 1'b0, ns_in_ready;
  logic [31:0] ns_in_instr = '0;
  logic        ns_out_valid;
  logic [10:0] ns_out_opcode;
  logic [63:0] ns_out_pc, ns_out_read_data1, ns_out_read_data2, ns_out_sign_ext;
  logic [4:0]  ns_out_rd;
  logic        ns_out_uncond_branch, ns_out_branch, ns_out_mem_read, ns_out_mem_to_reg;
  logic        ns_out_mem_write, ns_out_alu_src, ns_out_reg_write, ns_out_illegal;
  logic [1:0]  ns_out_alu_op;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] act_vec;
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pipe_decode #(.WORD(64), .INSTR_LEN(32), .LOAD_STALL(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .flush(flush), .wb_en(wb_en),
    .wb_addr(wb_addr), .wb_data(wb_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_opcode(out_opcode), .out_pc(out_pc), .out_rd(out_rd),
    .out_read_data1(out_read_data1), .out_read_data2(out_read_data2),
    .out_sign_ext(out_sign_ext), .out_uncond_branch(out_uncond_branch),
    .out_branch(out_branch), .out_mem_read(out_mem_read), .out_mem_to_reg(out_mem_to_reg),
    .out_mem_write(out_mem_write), .out_alu_src(out_alu_src), .out_reg_write(out_reg_write),
    .out_illegal(out_illegal), .out_alu_op(out_alu_op)
  );

  pipe_decode #(.WORD(64), .INSTR_LEN(32), .LOAD_STALL(0)) u_ns (
    .clk(clk), .rst_n(rst_n), .in_valid(ns_in_valid), .in_ready(ns_in_ready),
    .in_instr(ns_in_instr), .in_pc(64'h0), .flush(1'b0), .wb_en(1'b0),
    .wb_addr(5'd0), .wb_data(64'h0), .out_valid(ns_out_valid), .out_ready(1'b1),
    .out_opcode(ns_out_opcode), .out_pc(ns_out_pc), .out_rd(ns_out_rd),
    .out_read_data1(ns_out_read_data1), .out_read_data2(ns_out_read_data2),
    .out_sign_ext(ns_out_sign_ext), .out_uncond_branch(ns_out_uncond_branch),
    .out_branch(ns_out_branch), .out_mem_read(ns_out_mem_read),
    .out_mem_to_reg(ns_out_mem_to_reg), .out_mem_write(ns_out_mem_write),
    .out_alu_src(ns_out_alu_src), .out_reg_write(ns_out_reg_write),
    .out_illegal(ns_out_illegal), .out_alu_op(ns_out_alu_op)
  );

  assign act_vec = {out_opcode, out_pc, out_rd, out_read_data1, out_read_data2, out_sign_ext,
                    out_uncond_branch, out_branch, out_mem_read, out_mem_to_reg,
                    out_mem_write, out_alu_src, out_reg_write, out_illegal, out_alu_op};

  function automatic logic [31:0] r_ins(input logic [10:0] op, input logic [4:0] rm,
                                        input logic [4:0] rn, input logic [4:0] rd);
    return {op, rm, 6'd0, rn, rd};
  endfunction

  function automatic logic [31:0] d_ins(input logic [10:0] op, input logic [8:0] imm,
                                        input logic [4:0] rn, input logic [4:0] rt);
    return {op, imm, 2'b00, rn, rt};
  endfunction

  function automatic logic [W-1:0] mk(input logic [31:0] ins, input logic [63:0] pc,
                                      input logic [63:0] d1, input logic [63:0] d2,
                                      input logic [63:0] se, input logic [7:0] ctrl,
                                      input logic [1:0] aop);
    return {ins[31:21], pc, ins[4:0], d1, d2, se, ctrl, aop};
  endfunction

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send(input logic [31:0] ins, input logic [63:0] pc, input logic [W-1:0] e,
                      input bit push, output int waits);
    in_instr = ins;
    in_pc    = pc;
    in_valid = 1'b1;
    waits    = 0;
    @(negedge clk);
    while (!in_ready && waits < 20) begin
      waits++;
      @(negedge clk);
    end
    chk("send_ready", W'(in_ready), W'(1));
    if (in_ready && push) exp_q.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wb_write(input logic [4:0] a, input logic [63:0] d);
    wb_en = 1'b1; wb_addr = a; wb_data = d;
    @(posedge clk); #1;
    wb_en = 1'b0;
  endtask

  // Monitor: one comparison per completed ID/EX transfer.
  initial begin
    logic [W-1:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("unexpected_out", W'(1), W'(0));
        else begin
          e = exp_q.pop_front();
          chk("out_fields", act_vec, e);
        end
      end
    end
  end

  initial begin
    int w;
    logic [31:0] ins;

    // reset
    repeat (2) @(negedge clk);
    chk("rst_out_valid", W'(out_valid), W'(0));
    chk("rst_fields", act_vec, W'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;

    // basic R-type after writeback
    wb_write(5'd1, 64'h5);
    ins = r_ins(OP_ADD, 5'd1, 5'd1, 5'd2);
    send(ins, 64'h100, mk(ins, 64'h100, 64'h5, 64'h5, 64'h0, C_R, 2'b10), 1'b1, w);

    // load-use: one stall cycle, one bubble
    ins = d_ins(OP_LDUR, 9'h1F8, 5'd0, 5'd3);
    send(ins, 64'h104, mk(ins, 64'h104, 64'h0, 64'h0, 64'hFFFF_FFFF_FFFF_FFF8, C_LDUR, 2'b00),
         1'b1, w);
    ins = r_ins(OP_ADD, 5'd1, 5'd3, 5'd4);
    in_instr = ins; in_pc = 64'h108; in_valid = 1'b1;
    @(negedge clk);
    chk("stall_in_ready", W'(in_ready), W'(0));
    chk("stall_ldur_valid", W'(out_valid), W'(1));
    @(negedge clk);
    chk("bubble_out_valid", W'(out_valid), W'(0));
    chk("post_stall_ready", W'(in_ready), W'(1));
    if (in_ready) exp_q.push_back(mk(ins, 64'h108, 64'h0, 64'h5, 64'h0, C_R, 2'b10));
    @(posedge clk); #1;
    in_valid = 1'b0;

    // same-cycle writeback bypass
    wb_en = 1'b1; wb_addr = 5'd5; wb_data = 64'hAB;
    ins = r_ins(OP_SUB, 5'd5, 5'd5, 5'd6);
    send(ins, 64'h10C, mk(ins, 64'h10C, 64'hAB, 64'hAB, 64'h0, C_R, 2'b10), 1'b1, w);
    wb_en = 1'b0;

    // held output refresh
    wb_write(5'd7, 64'h77);
    out_ready = 1'b0;
    ins = r_ins(OP_ORR, 5'd5, 5'd7, 5'd8);
    send(ins, 64'h110, mk(ins, 64'h110, 64'h99, 64'hAB, 64'h0, C_R, 2'b10), 1'b1, w);
    @(negedge clk);
    chk("held_pre_refresh", W'(out_read_data1), W'(64'h77));
    @(posedge clk); #1;
    wb_write(5'd7, 64'h99);
    @(negedge clk);
    chk("held_valid", W'(out_valid), W'(1));
    chk("held_rd2_kept", W'(out_read_data2), W'(64'hAB));
    chk("held_in_ready", W'(in_ready), W'(0));
    @(posedge clk); #1;
    out_ready = 1'b1;

    // B with all-ones imm26, illegal, STUR, CBZ
    ins = {6'b000101, 26'h3FF_FFFF};
    send(ins, 64'h200, mk(ins, 64'h200, 64'h0, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, C_B, 2'b00),
         1'b1, w);
    ins = 32'h0;
    send(ins, 64'h204, mk(ins, 64'h204, 64'h0, 64'h0, 64'h0, C_ILL, 2'b00), 1'b1, w);
    ins = d_ins(OP_STUR, 9'd16, 5'd1, 5'd5);
    send(ins, 64'h208, mk(ins, 64'h208, 64'h5, 64'hAB, 64'd16, C_STUR, 2'b00), 1'b1, w);
    ins = {8'b10110100, 19'h7FFFF, 5'd7};
    send(ins, 64'h20C, mk(ins, 64'h20C, 64'h0, 64'h99, 64'hFFFF_FFFF_FFFF_FFFF, C_CBZ, 2'b01),
         1'b1, w);

    // reset in the middle of a load-use stall
    ins = d_ins(OP_LDUR, 9'd0, 5'd1, 5'd9);
    send(ins, 64'h300, mk(ins, 64'h300, 64'h5, 64'h0, 64'h0, C_LDUR, 2'b00), 1'b1, w);
    in_instr = r_ins(OP_ADD, 5'd9, 5'd9, 5'd10); in_valid = 1'b1;
    @(negedge clk);
    chk("rst_stall_ready", W'(in_ready), W'(0));
    #2;
    rst_n = 1'b0; in_valid = 1'b0;
    #1;
    chk("midrst_out_valid", W'(out_valid), W'(0));
    chk("midrst_fields", act_vec, W'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;

    // flush clears a held load's hazard; rf reset shows as X1=0
    out_ready = 1'b0;
    ins = d_ins(OP_LDUR, 9'd0, 5'd1, 5'd11);
    send(ins, 64'h400, '0, 1'b0, w);
    in_instr = r_ins(OP_ADD, 5'd1, 5'd11, 5'd12); in_valid = 1'b1; flush = 1'b1;
    @(negedge clk);
    chk("flush_in_ready", W'(in_ready), W'(0));
    chk("flush_pre_valid", W'(out_valid), W'(1));
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("flush_out_valid", W'(out_valid), W'(0));
    chk("flush_hazard_clr", W'(in_ready), W'(1));
    @(posedge clk); #1;
    out_ready = 1'b1;
    ins = r_ins(OP_ADD, 5'd1, 5'd11, 5'd12);
    send(ins, 64'h404, mk(ins, 64'h404, 64'h0, 64'h0, 64'h0, C_R, 2'b10), 1'b1, w);
    chk("flush_then_accept_waits", W'(w), W'(0));

    // LOAD_STALL=0: dependent instruction follows LDUR with no bubble
    ns_in_instr = d_ins(OP_LDUR, 9'h1F8, 5'd0, 5'd3); ns_in_valid = 1'b1;
    @(negedge clk);
    chk("ns_ldur_ready", W'(ns_in_ready), W'(1));
    @(posedge clk); #1;
    ns_in_instr = r_ins(OP_ADD, 5'd1, 5'd3, 5'd4);
    @(negedge clk);
    chk("ns_add_ready", W'(ns_in_ready), W'(1));
    chk("ns_ldur_out", W'({ns_out_valid, ns_out_opcode}), W'({1'b1, OP_LDUR}));
    @(posedge clk); #1;
    ns_in_valid = 1'b0;
    @(negedge clk);
    chk("ns_add_out", W'({ns_out_valid, ns_out_opcode}), W'({1'b1, OP_ADD}));

    repeat (4) @(negedge clk);
    chk("queue_drained", W'(exp_q.size()), W'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
